// File: rtl/counter_checker.sv
// Passive checker for a 4-bit up/down/load counter: predicts each next count and flags mismatches.
// Optional macro CHK_RESYNC_EN rebuilds each prediction from the observed count instead of the model's own.
module counter_checker #(
  parameter int ERR_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_rst,
  input  logic             mon_load,
  input  logic [3:0]       mon_d_in,
  input  logic             mon_up_dn,
  input  logic [3:0]       mon_count,
  output logic [3:0]       exp_count,
  output logic             synced,
  output logic             err,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_exp,
  output logic [3:0]       first_obs
);

  typedef enum logic [1:0] {UNSYNC, TRACK, HALT} state_t;

  state_t           state_q;
  logic [3:0]       exp_q, first_exp_q, first_obs_q;
  logic             synced_q, err_q, sticky_q;
  logic [ERR_W-1:0] cnt_q;

  logic             mismatch;
  logic [3:0]       base, pred_d, sync_d;

  // Counter next-value rule: reset beats load beats count; up wraps 13->0, down wraps into 10.
  function automatic logic [3:0] next_count(input logic [3:0] cnt, input logic r,
                                            input logic l, input logic [3:0] d,
                                            input logic dn);
    logic [3:0] nxt;
    if (r)                       nxt = 4'd0;
    else if (l)                  nxt = d;
    else if (!dn)                nxt = (cnt > 4'd12) ? 4'd0 : cnt + 4'd1;
    else if (cnt > 4'd10 || cnt < 4'd2) nxt = 4'd10;
    else                         nxt = cnt - 4'd1;
    return nxt;
  endfunction

  assign mismatch = (mon_count != exp_q);

`ifdef CHK_RESYNC_EN
  assign base = mon_count;
`else
  assign base = exp_q;
`endif

  assign pred_d = next_count(base, mon_rst, mon_load, mon_d_in, mon_up_dn);
  assign sync_d = next_count(mon_count, mon_rst, mon_load, mon_d_in, mon_up_dn);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UNSYNC;
      exp_q       <= '0;
      synced_q    <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else begin
      case (state_q)
        UNSYNC: begin
          exp_q    <= sync_d;
          state_q  <= TRACK;
          synced_q <= 1'b1;
          err_q    <= 1'b0;
        end
        TRACK: begin
          err_q <= mismatch;
          if (mismatch) begin
            sticky_q <= 1'b1;
            if (!sticky_q) begin
              first_exp_q <= exp_q;
              first_obs_q <= mon_count;
            end
            if (cnt_q != '1) cnt_q <= cnt_q + ERR_W'(1);
          end
          // A halting checker keeps the prediction that failed rather than advancing it.
          if (mismatch && STOP_ON_ERR) begin
            state_q  <= HALT;
            synced_q <= 1'b0;
          end else begin
            exp_q <= pred_d;
          end
        end
        HALT: begin
          err_q    <= 1'b0;
          synced_q <= 1'b0;
        end
        default: begin
          state_q  <= UNSYNC;
          synced_q <= 1'b0;
          err_q    <= 1'b0;
        end
      endcase
    end
  end

  assign exp_count  = exp_q;
  assign synced     = synced_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;
  assign first_exp  = first_exp_q;
  assign first_obs  = first_obs_q;

endmodule
